jbi_min_wdq_gen: RTL and testbench
==================================

// Module: jbi_min_wdq_gen
// PURPOSE
//  Parametrised write-decomposition queue for the JBI inbound (min) path. Buffers
//  parsed JBus header/data beats in a DEPTH-entry FIFO, then decomposes each
//  transaction into one header push to the target channel's RHQ and 0/1/LINE_BEATS
//  data pushes to its RDQ. Generalises channel count, data width, depth, line size;
//  adds data-error discard, overflow detection and hysteretic AOK flow control.
// PARAMETERS
//  NUM_CH      4    number of sctag request channels (RHQ/RDQ pairs)
//  CHW         2    channel select width, NUM_CH <= 2**CHW
//  DW          128  beat payload width
//  AW          4    buffer address width; DEPTH = 2**AW
//  LINE_BEATS  4    data beats per full-line write
//  BW          2    beat counter width, LINE_BEATS <= 2**BW
// PORTS
//  clk          in   1        core clock
//  rst_l        in   1        synchronous reset, active low
//  csr_iq_high  in   AW+1     occupancy at/above which aok_off pulses
//  csr_iq_low   in   AW+1     occupancy at/below which aok_on pulses (low < high)
//  in_push      in   1        beat valid this cycle
//  in_hdr       in   1        beat is a header (sideband fields valid)
//  in_ch        in   CHW      target channel (hdr only)
//  in_rw        in   1        1=read (header only, no data beats)
//  in_sub       in   1        1=subline write (one data beat, counts as wr8)
//  in_err       in   1        header: transaction carries data error -> discard
//  in_data      in   DW       beat payload
//  rhq_full     in   NUM_CH   per-channel header queue full (>=1 slot margin)
//  rdq_full     in   NUM_CH   per-channel data queue full (>=1 slot margin)
//  rhq_push     out  NUM_CH   one-hot header push
//  rdq_push     out  NUM_CH   one-hot data push
//  rq_wdata     out  DW       payload for rhq_push/rdq_push
//  wr_vld       out  1        pulse: last data beat of a write pushed
//  perf_wr8     out  1        pulse: subline write header pushed
//  aok_on/off   out  1        single-cycle flow-control pulses
//  ovf_err      out  1        sticky: push attempted while buffer full
//  occupancy    out  AW+1     current entry count
// BEHAVIOUR
//  - Reset (rst_l=0 at edge): FIFO pointers, count, beat_cnt cleared; FSM->IDLE;
//    all outputs 0; a transaction in flight is abandoned, no partial pushes.
//  - Entry = {hdr,ch,rw,sub,err,data}; write at edge when in_push & count<DEPTH.
//    Entry visible to drain side the following cycle. Pointers wrap mod DEPTH.
//  - in_push while count==DEPTH: beat dropped, ovf_err set until reset.
//  - Push and pop same cycle: count unchanged, legal at full and at empty.
//  - FSM IDLE: head valid & hdr -> HDR. Head valid & !hdr (orphan data): pop, discard.
//  - HDR: if err: pop, no push; rw -> IDLE, else DATA with beats_left set to
//    (sub?1:LINE_BEATS), data popped silently. Else if !rhq_full[ch]: pop,
//    rhq_push[ch] next cycle; rw -> IDLE, else DATA. rhq_full stalls in HDR.
//  - DATA: pop when head valid & !rdq_full[ch] (or discard mode); each pop gives
//    rdq_push[ch] next cycle; last beat -> IDLE and wr_vld with that push.
//    Buffer empty mid-packet: wait in DATA, no timeout.
//  - Push outputs registered: decision at t on full sampled at t, push at t+1;
//    max one push per cycle total; rq_wdata valid only with a push, else 0.
//  - Header beat in DATA position (malformed stream): treat as end of packet,
//    no pop, -> HDR. No wr_vld.
//  - AOK: level aok_state (reset 1). count_next>=iq_high & aok_state -> aok_off
//    pulse, state 0; count_next<=iq_low & !aok_state -> aok_on pulse, state 1.
//    Pulses registered, never both same cycle.
// TESTING
//  1 Full-line write ch2: hdr+4 beats D0..D3 -> rhq_push=4'b0100 once, rdq_push
//    4'b0100 x4 in order, wr_vld with D3, occupancy back to 0.
//  2 Subline write ch0 then read ch3 -> perf_wr8 once, one rdq push ch0, then
//    rhq_push=4'b1000 only, no rdq push for read.
//  3 rdq_full[1] held 10 cycles mid-line -> no pushes while held, resume with
//    remaining beats, none lost or duplicated.
//  4 iq_high=12, iq_low=4, rhq_full all 1, push 16 beats, then release ->
//    aok_off once at count 12, ovf_err stays 0; drain -> aok_on once at 4.
//  5 17 beats pushed with drain stalled -> 17th dropped, ovf_err=1 sticky,
//    occupancy=16; pointer wrap verified over 3 refills.
//  6 Header with in_err=1 + 4 beats -> no pushes, 5 entries consumed;
//    rst_l=0 during DATA -> outputs 0 next cycle, occupancy 0.

Source files
------------

// File: rtl/jbi_min_wdq_gen.sv
// Write-decomposition queue for the JBI inbound path: buffers header/data beats and
// splits each transaction into one RHQ header push plus 0/1/LINE_BEATS RDQ data pushes.
module jbi_min_wdq_gen #(
    parameter int NUM_CH     = 4,
    parameter int CHW        = 2,
    parameter int DW         = 128,
    parameter int AW         = 4,
    parameter int LINE_BEATS = 4,
    parameter int BW         = 2
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic [AW:0]       csr_iq_high,
    input  logic [AW:0]       csr_iq_low,
    input  logic              in_push,
    input  logic              in_hdr,
    input  logic [CHW-1:0]    in_ch,
    input  logic              in_rw,
    input  logic              in_sub,
    input  logic              in_err,
    input  logic [DW-1:0]     in_data,
    input  logic [NUM_CH-1:0] rhq_full,
    input  logic [NUM_CH-1:0] rdq_full,
    output logic [NUM_CH-1:0] rhq_push,
    output logic [NUM_CH-1:0] rdq_push,
    output logic [DW-1:0]     rq_wdata,
    output logic              wr_vld,
    output logic              perf_wr8,
    output logic              aok_on,
    output logic              aok_off,
    output logic              ovf_err,
    output logic [AW:0]       occupancy
);

    localparam int          DEPTH     = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [BW-1:0] LAST_OF_LINE = BW'(LINE_BEATS - 1);

    typedef struct packed {
        logic           hdr;
        logic [CHW-1:0] ch;
        logic           rw;
        logic           sub;
        logic           err;
        logic [DW-1:0]  data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA
    } state_t;

    entry_t         mem [DEPTH];
    entry_t         in_entry;
    entry_t         head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [AW:0]    count_next;
    logic           head_vld;
    logic           pop;
    logic           wr_en;

    state_t         state;
    logic [CHW-1:0] cur_ch;
    logic [BW-1:0]  beats_left;   // remaining beats minus one; 0 means current beat is last
    logic           discard;
    logic           aok_state;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CHW-1:0] ch);
        logic [NUM_CH-1:0] oh;
        oh     = '0;
        oh[ch] = 1'b1;
        return oh;
    endfunction

    assign in_entry = '{hdr: in_hdr, ch: in_ch, rw: in_rw, sub: in_sub,
                        err: in_err, data: in_data};
    assign head      = mem[rd_ptr];
    assign head_vld  = (count != '0);
    assign occupancy = count;

    // A full buffer still accepts a beat when the drain side frees a slot the same cycle.
    assign wr_en = in_push && ((count < DEPTH_CNT) || pop);

    // Drain decision: everything below depends only on state, head entry and full flags.
    always_comb begin
        pop = 1'b0;
        if (head_vld) begin
            unique case (state)
                S_IDLE:  pop = !head.hdr;
                S_HDR:   pop = head.err || !rhq_full[head.ch];
                S_DATA:  pop = !head.hdr && (discard || !rdq_full[cur_ch]);
                default: pop = 1'b0;
            endcase
        end
    end

    always_comb begin
        count_next = count;
        if (wr_en && !pop) begin
            count_next = count + 1'b1;
        end else if (!wr_en && pop) begin
            count_next = count - 1'b1;
        end
    end

    // NOTE: storage has no reset; validity is tracked by count/pointers, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            if (in_push && !wr_en) begin
                ovf_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state      <= S_IDLE;
            cur_ch     <= '0;
            beats_left <= '0;
            discard    <= 1'b0;
            rhq_push   <= '0;
            rdq_push   <= '0;
            rq_wdata   <= '0;
            wr_vld     <= 1'b0;
            perf_wr8   <= 1'b0;
        end else begin
            rhq_push <= '0;
            rdq_push <= '0;
            rq_wdata <= '0;
            wr_vld   <= 1'b0;
            perf_wr8 <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (head_vld && head.hdr) begin
                        state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (pop) begin
                        cur_ch     <= head.ch;
                        discard    <= head.err;
                        beats_left <= head.sub ? '0 : LAST_OF_LINE;
                        state      <= head.rw ? S_IDLE : S_DATA;
                        if (!head.err) begin
                            rhq_push <= ch_onehot(head.ch);
                            rq_wdata <= head.data;
                            perf_wr8 <= head.sub && !head.rw;
                        end
                    end
                end
                S_DATA: begin
                    // A header showing up here ends the packet early; it is not consumed.
                    if (head_vld && head.hdr) begin
                        state <= S_HDR;
                    end else if (pop) begin
                        if (!discard) begin
                            rdq_push <= ch_onehot(cur_ch);
                            rq_wdata <= head.data;
                            wr_vld   <= (beats_left == '0);
                        end
                        if (beats_left == '0) begin
                            state <= S_IDLE;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Hysteretic flow control: the level only flips at a threshold crossing, so pulses alternate.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            aok_state <= 1'b1;
            aok_on    <= 1'b0;
            aok_off   <= 1'b0;
        end else begin
            aok_on  <= 1'b0;
            aok_off <= 1'b0;
            if (aok_state && (count_next >= csr_iq_high)) begin
                aok_off   <= 1'b1;
                aok_state <= 1'b0;
            end else if (!aok_state && (count_next <= csr_iq_low)) begin
                aok_on    <= 1'b1;
                aok_state <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jbi_min_wdq_gen.sv
// Directed self-checking bench for jbi_min_wdq_gen; a negedge monitor logs every push
// and each scenario task compares the log against hand-derived expected sequences.
module tb_jbi_min_wdq_gen;

    typedef struct packed {
        logic         is_rdq;
        logic [3:0]   oh;
        logic [127:0] data;
        logic         wr_vld;
        logic         wr8;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst_l = 1'b0;
    logic [4:0]   csr_iq_high = 5'd12;
    logic [4:0]   csr_iq_low = 5'd4;
    logic         in_push = 1'b0;
    logic         in_hdr = 1'b0;
    logic [1:0]   in_ch = 2'd0;
    logic         in_rw = 1'b0;
    logic         in_sub = 1'b0;
    logic         in_err = 1'b0;
    logic [127:0] in_data = '0;
    logic [3:0]   rhq_full = '0;
    logic [3:0]   rdq_full = '0;
    logic [3:0]   rhq_push;
    logic [3:0]   rdq_push;
    logic [127:0] rq_wdata;
    logic         wr_vld;
    logic         perf_wr8;
    logic         aok_on;
    logic         aok_off;
    logic         ovf_err;
    logic [4:0]   occupancy;

    int   n_tests = 0;
    int   n_fail = 0;
    int   bad_cycles = 0;
    int   aok_on_cnt = 0;
    int   aok_off_cnt = 0;
    logic [4:0] occ_at_on = '0;
    logic [4:0] occ_at_off = '0;
    ev_t  evq[$];

    jbi_min_wdq_gen dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .csr_iq_high (csr_iq_high),
        .csr_iq_low  (csr_iq_low),
        .in_push     (in_push),
        .in_hdr      (in_hdr),
        .in_ch       (in_ch),
        .in_rw       (in_rw),
        .in_sub      (in_sub),
        .in_err      (in_err),
        .in_data     (in_data),
        .rhq_full    (rhq_full),
        .rdq_full    (rdq_full),
        .rhq_push    (rhq_push),
        .rdq_push    (rdq_push),
        .rq_wdata    (rq_wdata),
        .wr_vld      (wr_vld),
        .perf_wr8    (perf_wr8),
        .aok_on      (aok_on),
        .aok_off     (aok_off),
        .ovf_err     (ovf_err),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge away from register updates.
    always @(negedge clk) begin
        if (rst_l) begin
            if (rhq_push != '0) evq.push_back('{1'b0, rhq_push, rq_wdata, wr_vld, perf_wr8});
            if (rdq_push != '0) evq.push_back('{1'b1, rdq_push, rq_wdata, wr_vld, perf_wr8});
            if (rhq_push != '0 && rdq_push != '0) bad_cycles++;
            if ($countones(rhq_push) > 1 || $countones(rdq_push) > 1) bad_cycles++;
            if (rhq_push == '0 && rdq_push == '0 && rq_wdata != '0) bad_cycles++;
            if (wr_vld && rdq_push == '0) bad_cycles++;
            if (perf_wr8 && rhq_push == '0) bad_cycles++;
            if (aok_on && aok_off) bad_cycles++;
            if (aok_off) begin aok_off_cnt++; occ_at_off = occupancy; end
            if (aok_on) begin aok_on_cnt++; occ_at_on = occupancy; end
        end
    end

    function automatic ev_t mk_ev(input logic is_rdq, input logic [3:0] oh,
                                  input logic [127:0] data, input logic wv, input logic w8);
        ev_t e;
        e = '{is_rdq, oh, data, wv, w8};
        return e;
    endfunction

    task automatic push_beat(input logic hdr, input logic [1:0] ch, input logic rw,
                             input logic sub, input logic err, input logic [127:0] data);
        in_push = 1'b1; in_hdr = hdr; in_ch = ch; in_rw = rw;
        in_sub = sub; in_err = err; in_data = data;
        @(negedge clk);
        in_push = 1'b0; in_hdr = 1'b0; in_ch = 2'd0; in_rw = 1'b0;
        in_sub = 1'b0; in_err = 1'b0; in_data = '0;
    endtask

    // Bounded wait for the buffer to drain; a timeout is reported as a failure.
    task automatic wait_empty(input string name);
        int n = 0;
        while (occupancy != 5'd0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (occupancy !== 5'd0) begin
            n_fail++;
            $display("FAIL %s drain: occupancy=%0d, expected 0", name, occupancy);
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({rhq_push, rdq_push, wr_vld, perf_wr8, aok_on, aok_off, ovf_err} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 0",
                     {rhq_push, rdq_push, wr_vld, perf_wr8, aok_on, aok_off, ovf_err});
        end
        n_tests++;
        if (occupancy !== 5'd0 || rq_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: occupancy=%0d wdata=%h, expected 0/0", occupancy, rq_wdata);
        end
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_line();
        ev_t exp[$];
        ev_t got;
        evq.delete();
        push_beat(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 128'h1000);
        for (int i = 0; i < 4; i++) push_beat(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 128'hD0 + 128'(i));
        exp.push_back(mk_ev(1'b0, 4'b0100, 128'h1000, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) exp.push_back(mk_ev(1'b1, 4'b0100, 128'hD0 + 128'(i), (i == 3), 1'b0));
        wait_empty("full_line");
        n_tests++;
        if (evq.size() != exp.size()) begin
            n_fail++;
            $display("FAIL full_line count: got %0d, expected %0d", evq.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < evq.size()) ? evq[i] : '0;
            n_tests++;
            if (got !== exp[i]) begin
                n_fail++;
                $display("FAIL full_line ev%0d: got %h, expected %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_sub_and_read();
        ev_t exp[$];
        ev_t got;
        evq.delete();
        push_beat(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 128'h2000);
        push_beat(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 128'h2001);
        push_beat(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 128'h3000);
        exp.push_back(mk_ev(1'b0, 4'b0001, 128'h2000, 1'b0, 1'b1));
        exp.push_back(mk_ev(1'b1, 4'b0001, 128'h2001, 1'b1, 1'b0));
        exp.push_back(mk_ev(1'b0, 4'b1000, 128'h3000, 1'b0, 1'b0));
        wait_empty("sub_read");
        n_tests++;
        if (evq.size() != exp.size()) begin
            n_fail++;
            $display("FAIL sub_read count: got %0d, expected %0d", evq.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < evq.size()) ? evq[i] : '0;
            n_tests++;
            if (got !== exp[i]) begin
                n_fail++;
                $display("FAIL sub_read ev%0d: got %h, expected %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_rdq_stall();
        ev_t exp[$];
        ev_t got;
        int  n = 0;
        evq.delete();
        push_beat(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 128'hA0);
        push_beat(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 128'hA1);
        push_beat(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 128'hA2);
        while (evq.size() < 3 && n < 50) begin @(negedge clk); n++; end
        rdq_full = 4'b0010;
        push_beat(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 128'hA3);
        push_beat(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 128'hA4);
        repeat (8) @(negedge clk);
        n_tests++;
        if (evq.size() != 3 || occupancy !== 5'd2) begin
            n_fail++;
            $display("FAIL rdq_stall hold: events=%0d occupancy=%0d, expected 3/2", evq.size(), occupancy);
        end
        rdq_full = 4'b0000;
        exp.push_back(mk_ev(1'b0, 4'b0010, 128'hA0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) exp.push_back(mk_ev(1'b1, 4'b0010, 128'hA1 + 128'(i), (i == 3), 1'b0));
        wait_empty("rdq_stall");
        n_tests++;
        if (evq.size() != exp.size()) begin
            n_fail++;
            $display("FAIL rdq_stall count: got %0d, expected %0d", evq.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < evq.size()) ? evq[i] : '0;
            n_tests++;
            if (got !== exp[i]) begin
                n_fail++;
                $display("FAIL rdq_stall ev%0d: got %h, expected %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_aok();
        ev_t got;
        evq.delete();
        aok_on_cnt = 0; aok_off_cnt = 0;
        rhq_full = 4'b1111;
        for (int i = 0; i < 16; i++) push_beat(1'b1, 2'(i % 4), 1'b1, 1'b0, 1'b0, 128'h100 + 128'(i));
        @(negedge clk);
        n_tests++;
        if (occupancy !== 5'd16 || ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL aok_fill: occupancy=%0d ovf=%b, expected 16/0", occupancy, ovf_err);
        end
        n_tests++;
        if (aok_off_cnt != 1 || occ_at_off !== 5'd12 || aok_on_cnt != 0) begin
            n_fail++;
            $display("FAIL aok_off: off=%0d at %0d on=%0d, expected 1 at 12, on 0",
                     aok_off_cnt, occ_at_off, aok_on_cnt);
        end
        rhq_full = 4'b0000;
        wait_empty("aok");
        n_tests++;
        if (aok_on_cnt != 1 || occ_at_on !== 5'd4 || aok_off_cnt != 1) begin
            n_fail++;
            $display("FAIL aok_on: on=%0d at %0d off=%0d, expected 1 at 4, off 1",
                     aok_on_cnt, occ_at_on, aok_off_cnt);
        end
        n_tests++;
        if (evq.size() != 16) begin
            n_fail++;
            $display("FAIL aok_drain count: got %0d, expected 16", evq.size());
        end
        for (int i = 0; i < 16; i++) begin
            got = (i < evq.size()) ? evq[i] : '0;
            n_tests++;
            if (got !== mk_ev(1'b0, 4'(1 << (i % 4)), 128'h100 + 128'(i), 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL aok_drain ev%0d: got %h, expected %h", i, got,
                         mk_ev(1'b0, 4'(1 << (i % 4)), 128'h100 + 128'(i), 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_overflow_wrap();
        ev_t got;
        for (int r = 0; r < 3; r++) begin
            evq.delete();
            rhq_full = 4'b1111;
            for (int i = 0; i < 16; i++) push_beat(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 128'(r * 256 + i));
            if (r == 0) push_beat(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 128'hBAD);
            @(negedge clk);
            n_tests++;
            if (occupancy !== 5'd16 || ovf_err !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_fill%0d: occupancy=%0d ovf=%b, expected 16/1", r, occupancy, ovf_err);
            end
            rhq_full = 4'b0000;
            wait_empty("ovf_wrap");
            n_tests++;
            if (evq.size() != 16 || ovf_err !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: events=%0d ovf=%b, expected 16/1", r, evq.size(), ovf_err);
            end
            for (int i = 0; i < 16; i++) begin
                got = (i < evq.size()) ? evq[i] : '0;
                n_tests++;
                if (got !== mk_ev(1'b0, 4'b0001, 128'(r * 256 + i), 1'b0, 1'b0)) begin
                    n_fail++;
                    $display("FAIL ovf_drain%0d ev%0d: got %h, expected %h", r, i, got,
                             mk_ev(1'b0, 4'b0001, 128'(r * 256 + i), 1'b0, 1'b0));
                end
            end
        end
    endtask

    task automatic test_err_and_reset();
        evq.delete();
        push_beat(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 128'hE0);
        for (int i = 0; i < 4; i++) push_beat(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 128'hE1 + 128'(i));
        wait_empty("err_discard");
        repeat (4) @(negedge clk);
        n_tests++;
        if (evq.size() != 0) begin
            n_fail++;
            $display("FAIL err_discard: got %0d pushes, expected 0", evq.size());
        end
        // Open a line on ch2, push one beat, then park two more behind rdq_full.
        push_beat(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 128'hF0);
        push_beat(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 128'hF1);
        repeat (5) @(negedge clk);
        rdq_full = 4'b0100;
        push_beat(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 128'hF2);
        push_beat(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 128'hF3);
        n_tests++;
        if (evq.size() != 2 || occupancy !== 5'd2) begin
            n_fail++;
            $display("FAIL mid_data setup: events=%0d occupancy=%0d, expected 2/2", evq.size(), occupancy);
        end
        rst_l = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({rhq_push, rdq_push, wr_vld, perf_wr8, aok_on, aok_off, ovf_err} !== 15'd0
            || rq_wdata !== '0 || occupancy !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_data reset: ctrl=%b wdata=%h occupancy=%0d, expected all 0",
                     {rhq_push, rdq_push, wr_vld, perf_wr8, aok_on, aok_off, ovf_err}, rq_wdata, occupancy);
        end
        rst_l = 1'b1;
        rdq_full = 4'b0000;
        evq.delete();
        repeat (10) @(negedge clk);
        n_tests++;
        if (evq.size() != 0 || occupancy !== 5'd0) begin
            n_fail++;
            $display("FAIL post_reset idle: events=%0d occupancy=%0d, expected 0/0", evq.size(), occupancy);
        end
    endtask

    task automatic test_protocol();
        n_tests++;
        if (bad_cycles != 0) begin
            n_fail++;
            $display("FAIL protocol: %0d illegal output cycles, expected 0", bad_cycles);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_line();
        test_sub_and_read();
        test_rdq_stall();
        test_aok();
        test_overflow_wrap();
        test_err_and_reset();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
